// File: rtl/victim_wbuf_pkg.sv
// ============================================================================
// Module   : victim_wbuf_pkg
// Purpose  : Shared types and constants for the victim write buffer: bridge
//            write-type codes, line offset, drain FSM encoding and the FIFO
//            entry layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package victim_wbuf_pkg;

  // Bridge write-type codes
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_LINE = 3'b100;

  // A dirty line covers 16 bytes; words cover 4 bytes
  localparam int LINE_OFS = 4;
  localparam int WORD_OFS = 2;

  // Drain state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } wb_state_e;

  // One buffered write
  typedef struct packed {
    logic         line;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [1:0]   size;
    logic [127:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/victim_wbuf_fifo.sv
// ============================================================================
// Module   : wbuf_fifo
// Purpose  : Entry storage for the victim write buffer. Circular buffer with
//            read/write pointers and an occupancy count; exposes every slot
//            with a per-slot valid mask so the owner can run hazard compares.
// Ports    : aclk, aresetn  - clock, synchronous active-low reset
//            push/push_entry - write one entry at the tail
//            pop             - retire the head entry
//            entries/valid   - all storage slots and their occupancy
//            rd_ptr/count    - head index and number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbuf_fifo
  import victim_wbuf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t [DEPTH-1:0]    entries,
  output logic      [DEPTH-1:0]    valid,
  output logic      [PTR_W-1:0]    rd_ptr,
  output logic      [CNT_W-1:0]    count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic      [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; validity comes from the pointers
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign entries = mem;

  // Slot i is occupied when its distance from the head is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic [PTR_W-1:0] ofs;
    assign ofs      = IDX - rd_ptr;
    assign valid[i] = ({1'b0, ofs} < count);
  end

endmodule

`default_nettype wire

// File: rtl/victim_wbuf.sv
// ============================================================================
// Module   : victim_wbuf
// Purpose  : Victim / uncached write buffer between the dcache and the bus
//            bridge. Queues dirty lines and uncached word writes, drains them
//            in order through a req/addr_ok/data_ok handshake and reports
//            address hazards for pending entries.
// Ports    : aclk, aresetn          - clock, synchronous active-low reset
//            wb_*                   - dcache push (valid/ready + entry fields)
//            req, wr, size, wstrb,
//            addr, wr_type, wr_data - bridge write request
//            addr_ok, data_ok       - bridge address / data acknowledges
//            chk_addr, chk_hit      - read-after-write hazard probe
//            empty                  - nothing stored and drain idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module victim_wbuf
  import victim_wbuf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  // dcache push
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic         wb_line,
  input  logic [31:0]  wb_addr,
  input  logic [3:0]   wb_wstrb,
  input  logic [1:0]   wb_size,
  input  logic [127:0] wb_data,
  // bridge write request
  output logic         req,
  output logic         wr,
  output logic [1:0]   size,
  output logic [3:0]   wstrb,
  output logic [31:0]  addr,
  output logic [2:0]   wr_type,
  output logic [127:0] wr_data,
  input  logic         addr_ok,
  input  logic         data_ok,
  // hazard check
  input  logic [31:0]  chk_addr,
  output logic         chk_hit,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_state_e             state;
  wb_state_e             state_nxt;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic      [DEPTH-1:0] hit_vec;
  logic      [PTR_W-1:0] rd_ptr;
  logic      [CNT_W-1:0] count;
  logic                  unused_chk_lsb;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign wb_ready = (count != CNT_W'(DEPTH));
  assign push     = wb_valid && wb_ready;

  assign push_entry = '{line:  wb_line,
                        addr:  wb_addr,
                        wstrb: wb_wstrb,
                        size:  wb_size,
                        data:  wb_data};

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .entries    (entries),
    .valid      (valid),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  assign head = entries[rd_ptr];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (count != '0) state_nxt = ST_REQ;
      ST_REQ:  if (addr_ok)     state_nxt = ST_WAIT;
      // Go straight back to REQ when something remains after this pop
      ST_WAIT: if (data_ok)     state_nxt = ((count != CNT_W'(1)) || push) ? ST_REQ : ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    req   = (state == ST_REQ);
    pop   = (state == ST_WAIT) && data_ok;
    empty = (state == ST_IDLE) && (count == '0);
  end

  // Request fields are taken from the head, which cannot change until its pop
  always_comb begin
    wr      = 1'b1;
    addr    = head.addr;
    wr_type = WR_TYPE_WORD;
    wstrb   = head.wstrb;
    size    = head.size;
    wr_data = head.data;
    if (head.line) begin
      addr    = {head.addr[31:LINE_OFS], {LINE_OFS{1'b0}}};
      wr_type = WR_TYPE_LINE;
      wstrb   = 4'hf;
      size    = 2'b10;
    end
  end

  // Hazard compare: only stored entries count, so the in-flight head stays
  // visible until data_ok and an entry being pushed this cycle is excluded.
  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    logic line_hit;
    logic word_hit;
    assign line_hit   = (chk_addr[31:LINE_OFS] == entries[i].addr[31:LINE_OFS]);
    assign word_hit   = (chk_addr[31:WORD_OFS] == entries[i].addr[31:WORD_OFS]);
    assign hit_vec[i] = valid[i] && (entries[i].line ? line_hit : word_hit);
  end

  assign chk_hit = |hit_vec;

  // Byte offset within a word never matters for the hazard
  assign unused_chk_lsb = &{1'b0, chk_addr[WORD_OFS-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_victim_wbuf.sv
`default_nettype none

module tb_victim_wbuf;

  localparam int DEPTH = 2;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         wb_valid, wb_ready, wb_line;
  logic [31:0]  wb_addr;
  logic [3:0]   wb_wstrb;
  logic [1:0]   wb_size;
  logic [127:0] wb_data;
  logic         req, wr;
  logic [1:0]   size;
  logic [3:0]   wstrb;
  logic [31:0]  addr;
  logic [2:0]   wr_type;
  logic [127:0] wr_data;
  logic         addr_ok, data_ok;
  logic [31:0]  chk_addr;
  logic         chk_hit, empty;

  int n_cmp = 0;
  int n_bad = 0;

  victim_wbuf #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line), .wb_addr(wb_addr),
    .wb_wstrb(wb_wstrb), .wb_size(wb_size), .wb_data(wb_data),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wr_type(wr_type),
    .wr_data(wr_data), .addr_ok(addr_ok), .data_ok(data_ok),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty)
  );

  always #5 aclk = ~aclk;

  // Reference model entry
  typedef struct {
    bit           line;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [1:0]   sz;
    logic [127:0] d;
  } ment_t;

  ment_t mq[$];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_push(input bit ln, input logic [31:0] a, input logic [3:0] s,
                            input logic [1:0] sz, input logic [127:0] d);
    wb_valid = 1'b1; wb_line = ln; wb_addr = a; wb_wstrb = s; wb_size = sz; wb_data = d;
  endtask

  task automatic hs_addr();
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
  endtask

  task automatic hs_data();
    data_ok = 1'b1; tick(); data_ok = 1'b0;
  endtask

  // ---------------------------------------------------------------- reset
  task automatic test_reset();
    aresetn = 1'b0; chk_addr = 32'h0;
    tick(); tick();
    n_cmp++; if (req !== 1'b0)      begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
    n_cmp++; if (empty !== 1'b1)    begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", wb_ready); end
    n_cmp++; if (chk_hit !== 1'b0)  begin n_bad++; $display("FAIL reset_chk_hit: got %b want 0", chk_hit); end
    n_cmp++; if (wr !== 1'b1)       begin n_bad++; $display("FAIL reset_wr: got %b want 1", wr); end
    aresetn = 1'b1;
    tick();
  endtask

  // ------------------------------------------------------- single line push
  task automatic test_line_push();
    logic [127:0] d = 128'h00000004_00000003_00000002_00000001;
    drive_push(1'b1, 32'h1c000040, 4'h3, 2'b00, d);
    tick(); wb_valid = 1'b0;
    n_cmp++; if (req !== 1'b0)   begin n_bad++; $display("FAIL line_req_early: got %b want 0", req); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL line_not_empty: got %b want 0", empty); end
    tick();
    n_cmp++;
    if ({req, addr, wr_type, wstrb, size, wr_data} !== {1'b1, 32'h1c000040, 3'b100, 4'hf, 2'b10, d}) begin
      n_bad++;
      $display("FAIL line_req_fields: got req=%b addr=%h type=%b wstrb=%h size=%b data=%h want req=1 addr=1c000040 type=100 wstrb=f size=10 data=%h",
               req, addr, wr_type, wstrb, size, wr_data, d);
    end
    hs_addr();
    n_cmp++; if (req !== 1'b0)   begin n_bad++; $display("FAIL line_req_drop: got %b want 0", req); end
    hs_data();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL line_empty_after: got %b want 1", empty); end
  endtask

  // -------------------------------------------- two entries, slow addr_ok
  task automatic test_backpressure();
    logic [127:0] da = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] db = {$urandom, $urandom, $urandom, $urandom};
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_start: got %b want 1", wb_ready); end
    drive_push(1'b1, 32'h1c000108, 4'h1, 2'b01, da); tick();
    drive_push(1'b0, 32'h1c000206, 4'b0011, 2'b01, db); tick();
    wb_valid = 1'b0;
    n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", wb_ready); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({req, addr, wr_type, wstrb, size, wr_data} !== {1'b1, 32'h1c000100, 3'b100, 4'hf, 2'b10, da}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got req=%b addr=%h type=%b wstrb=%h size=%b want req=1 addr=1c000100 type=100 wstrb=f size=10",
                 k, req, addr, wr_type, wstrb, size);
      end
      tick();
    end
    hs_addr(); hs_data();
    n_cmp++;
    if ({req, addr, wr_type, wstrb, size, wr_data[31:0]} !== {1'b1, 32'h1c000206, 3'b010, 4'b0011, 2'b01, db[31:0]}) begin
      n_bad++;
      $display("FAIL bp_second: got req=%b addr=%h type=%b wstrb=%b size=%b data=%h want req=1 addr=1c000206 type=010 wstrb=0011 size=01 data=%h",
               req, addr, wr_type, wstrb, size, wr_data[31:0], db[31:0]);
    end
    hs_addr(); hs_data();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL bp_empty: got %b want 1", empty); end
  endtask

  // ---------------------------------- full FIFO, pop and push same cycle
  task automatic test_full_collision();
    logic [127:0] dc = {$urandom, $urandom, $urandom, $urandom};
    drive_push(1'b0, 32'h00000010, 4'h1, 2'b00, 128'h11); tick();
    drive_push(1'b0, 32'h00000020, 4'h2, 2'b00, 128'h22); tick();
    wb_valid = 1'b0;
    hs_addr();
    drive_push(1'b1, 32'h00000030, 4'h0, 2'b00, dc);
    data_ok = 1'b1;
    #1;
    n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_collide: got %b want 0", wb_ready); end
    tick(); data_ok = 1'b0;
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_pop: got %b want 1", wb_ready); end
    n_cmp++;
    if ({req, addr} !== {1'b1, 32'h00000020}) begin
      n_bad++; $display("FAIL full_next_head: got req=%b addr=%h want req=1 addr=00000020", req, addr);
    end
    tick(); wb_valid = 1'b0;
    n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL full_refilled: got %b want 0", wb_ready); end
    hs_addr(); hs_data();
    n_cmp++;
    if ({req, addr, wr_type, wr_data} !== {1'b1, 32'h00000030, 3'b100, dc}) begin
      n_bad++; $display("FAIL full_third: got req=%b addr=%h type=%b want req=1 addr=00000030 type=100", req, addr, wr_type);
    end
    hs_addr(); hs_data();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_empty: got %b want 1", empty); end
  endtask

  // ------------------------------------------------------------ hazards
  task automatic test_hazard();
    drive_push(1'b1, 32'h00001230, 4'hf, 2'b10, 128'h5);
    chk_addr = 32'h0000123c;
    #1;
    n_cmp++; if (chk_hit !== 1'b0) begin n_bad++; $display("FAIL haz_pushing: got %b want 0", chk_hit); end
    tick(); wb_valid = 1'b0;
    n_cmp++; if (chk_hit !== 1'b1) begin n_bad++; $display("FAIL haz_same_line: got %b want 1", chk_hit); end
    chk_addr = 32'h00001240; #1;
    n_cmp++; if (chk_hit !== 1'b0) begin n_bad++; $display("FAIL haz_next_line: got %b want 0", chk_hit); end
    chk_addr = 32'h0000123c;
    tick(); hs_addr();
    n_cmp++; if (chk_hit !== 1'b1) begin n_bad++; $display("FAIL haz_in_flight: got %b want 1", chk_hit); end
    hs_data();
    n_cmp++; if (chk_hit !== 1'b0) begin n_bad++; $display("FAIL haz_retired: got %b want 0", chk_hit); end
  endtask

  // ------------------------------------------------------- uncached word
  task automatic test_word();
    logic [127:0] d = {$urandom, $urandom, $urandom, 32'hcafef00d};
    drive_push(1'b0, 32'hbfaf8002, 4'b0100, 2'b00, d);
    tick(); wb_valid = 1'b0; tick();
    n_cmp++;
    if ({req, addr, wr_type, wstrb, size, wr_data[31:0]} !== {1'b1, 32'hbfaf8002, 3'b010, 4'b0100, 2'b00, 32'hcafef00d}) begin
      n_bad++;
      $display("FAIL word_fields: got req=%b addr=%h type=%b wstrb=%b size=%b data=%h want req=1 addr=bfaf8002 type=010 wstrb=0100 size=00 data=cafef00d",
               req, addr, wr_type, wstrb, size, wr_data[31:0]);
    end
    chk_addr = 32'hbfaf8001; #1;
    n_cmp++; if (chk_hit !== 1'b1) begin n_bad++; $display("FAIL word_hit: got %b want 1", chk_hit); end
    chk_addr = 32'hbfaf8004; #1;
    n_cmp++; if (chk_hit !== 1'b0) begin n_bad++; $display("FAIL word_miss: got %b want 0", chk_hit); end
    hs_addr(); hs_data();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL word_empty: got %b want 1", empty); end
  endtask

  // ------------------------------------------------- reset during drain
  task automatic test_reset_mid_drain();
    drive_push(1'b1, 32'h1c000400, 4'hf, 2'b10, 128'h77); tick();
    drive_push(1'b0, 32'h1c000500, 4'h1, 2'b00, 128'h88); tick();
    wb_valid = 1'b0;
    hs_addr();
    chk_addr = 32'h1c000404;
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    n_cmp++;
    if ({req, empty, wb_ready, chk_hit} !== 4'b0110) begin
      n_bad++; $display("FAIL rst_drain: got req=%b empty=%b ready=%b hit=%b want 0 1 1 0", req, empty, wb_ready, chk_hit);
    end
    hs_data();
    n_cmp++;
    if ({req, empty, wb_ready} !== 3'b011) begin
      n_bad++; $display("FAIL rst_stray_data_ok: got req=%b empty=%b ready=%b want 0 1 1", req, empty, wb_ready);
    end
    hs_addr(); tick();
    n_cmp++;
    if ({req, empty} !== 2'b01) begin
      n_bad++; $display("FAIL rst_stray_addr_ok: got req=%b empty=%b want 0 1", req, empty);
    end
  endtask

  // -------------------------------- randomized traffic vs queue model
  task automatic test_random();
    bit     inflight = 1'b0;
    bit     fresh = 1'b0;
    bit     exp_req, exp_hit, exp_ready, exp_empty, push_ev, acc_ev, pop_ev, was_empty;
    ment_t  h, n;
    logic [31:0] exp_addr;
    logic [2:0]  exp_type;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_size;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Last cycles stop pushing and acknowledge everything to drain
      if (cyc < 2950) begin
        wb_valid = ($urandom_range(0, 1) == 1);
        addr_ok  = ($urandom_range(0, 2) == 0);
        data_ok  = ($urandom_range(0, 2) == 0);
      end else begin
        wb_valid = 1'b0; addr_ok = 1'b1; data_ok = 1'b1;
      end
      wb_line  = $urandom_range(0, 1);
      wb_addr  = 32'h1c000000 | 32'($urandom_range(0, 255));
      wb_wstrb = 4'($urandom); wb_size = 2'($urandom);
      wb_data  = {$urandom, $urandom, $urandom, $urandom};
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        chk_addr = mq[$urandom_range(0, mq.size() - 1)].a ^ ($urandom & 32'h1f);
      else
        chk_addr = 32'h1c000000 | 32'($urandom_range(0, 511));
      #2;

      exp_ready = (mq.size() != DEPTH);
      exp_empty = (mq.size() == 0);
      exp_req   = (mq.size() != 0) && !inflight && !fresh;
      exp_hit   = 1'b0;
      foreach (mq[k])
        if (mq[k].line ? (chk_addr[31:4] == mq[k].a[31:4]) : (chk_addr[31:2] == mq[k].a[31:2])) exp_hit = 1'b1;

      n_cmp++; if (wb_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, wb_ready, exp_ready); end
      n_cmp++; if (empty !== exp_empty)    begin n_bad++; $display("FAIL rnd_empty@%0d: got %b want %b", cyc, empty, exp_empty); end
      n_cmp++; if (req !== exp_req)        begin n_bad++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, req, exp_req); end
      n_cmp++; if (chk_hit !== exp_hit)    begin n_bad++; $display("FAIL rnd_hit@%0d: addr %h got %b want %b", cyc, chk_addr, chk_hit, exp_hit); end
      if (exp_req) begin
        h        = mq[0];
        exp_addr = h.line ? {h.a[31:4], 4'h0} : h.a;
        exp_type = h.line ? 3'b100 : 3'b010;
        exp_strb = h.line ? 4'hf : h.s;
        exp_size = h.line ? 2'b10 : h.sz;
        n_cmp++;
        if ({addr, wr_type, wstrb, size} !== {exp_addr, exp_type, exp_strb, exp_size} ||
            (h.line ? (wr_data !== h.d) : (wr_data[31:0] !== h.d[31:0]))) begin
          n_bad++;
          $display("FAIL rnd_fields@%0d: got addr=%h type=%b wstrb=%h size=%b data=%h want addr=%h type=%b wstrb=%h size=%b data=%h",
                   cyc, addr, wr_type, wstrb, size, wr_data, exp_addr, exp_type, exp_strb, exp_size, h.d);
        end
      end

      push_ev = wb_valid && exp_ready;
      acc_ev  = addr_ok && exp_req;
      pop_ev  = data_ok && inflight;
      n = '{line: wb_line, a: wb_addr, s: wb_wstrb, sz: wb_size, d: wb_data};
      tick();

      was_empty = (mq.size() == 0);
      if (pop_ev) begin void'(mq.pop_front()); inflight = 1'b0; end
      if (acc_ev) inflight = 1'b1;
      fresh = 1'b0;
      if (push_ev) begin
        mq.push_back(n);
        if (was_empty) fresh = 1'b1;
      end
    end
    wb_valid = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rnd_drained: got %b want 1", empty); end
  endtask

  initial begin
    aresetn = 1'b0; wb_valid = 1'b0; wb_line = 1'b0; wb_addr = '0; wb_wstrb = '0;
    wb_size = '0; wb_data = '0; addr_ok = 1'b0; data_ok = 1'b0; chk_addr = '0;
    test_reset();
    test_line_push();
    test_backpressure();
    test_full_collision();
    test_hazard();
    test_word();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/victim_wbuf.md
VICTIM_WBUF -- requirements
Module: victim_wbuf

Interface
REQ-001 SHALL provide ports: aclk input 1 clock; aresetn input 1 synchronous active-low reset.
REQ-002 SHALL provide dcache-side push: wb_valid in 1; wb_ready out 1; wb_line in 1 (1=128-bit dirty line, 0=single uncached word); wb_addr in 32; wb_wstrb in 4; wb_size in 2; wb_data in 128 (word writes use [31:0]).
REQ-003 SHALL provide bridge-side write request: req out 1; wr out 1 (constant 1); size out 2; wstrb out 4; addr out 32; wr_type out 3; wr_data out 128; addr_ok in 1; data_ok in 1.
REQ-004 SHALL provide hazard check: chk_addr in 32; chk_hit out 1 (chk_addr matches a pending entry); empty out 1.
REQ-005 SHALL use parameter DEPTH, default 2, FIFO entry count; legal values 2 and 4.

Function
REQ-006 SHALL store entries FIFO-ordered: {line, addr, wstrb, size, data}; push on wb_valid&&wb_ready.
REQ-007 SHALL drive wb_ready = (count != DEPTH) from registered count; a push when full is impossible, with no same-cycle bypass of a pop.
REQ-008 SHALL run drain FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-009 IDLE: when count != 0, SHALL go to REQ next cycle; the head entry is pushed at earliest one cycle before req rises.
REQ-010 REQ: SHALL hold req=1 and all request fields stable from the head entry until addr_ok=1, then go to WAIT; req SHALL drop the cycle after addr_ok.
REQ-011 WAIT: req=0; on data_ok=1, SHALL pop the head, decrement count, and go to IDLE (REQ if count after pop != 0, without an IDLE cycle).
REQ-012 SHALL drive wr_type = 3'b100 for line entries and 3'b010 for word entries; wstrb = 4'hf and size = 2'b10 for lines, stored values for words.
REQ-013 SHALL drive addr = {addr[31:4],4'b0} for lines and the stored address for words.
REQ-014 On simultaneous push and pop (data_ok in WAIT with wb_valid&&wb_ready), count SHALL remain unchanged, and both pointers SHALL advance.
REQ-015 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-016 chk_hit SHALL be combinational: OR over valid entries of (chk_addr[31:4]==entry.addr[31:4]) for lines, or (chk_addr[31:2]==entry.addr[31:2]) for words; it includes the entry in flight until its data_ok.
REQ-017 chk_hit SHALL NOT include an entry being pushed in the current cycle; dcache SHALL stall reads while chk_hit=1.
REQ-018 empty SHALL be (count==0) && state==IDLE.
REQ-019 addr_ok or data_ok arriving outside REQ/WAIT respectively SHALL be ignored.

Reset
REQ-020 On aresetn=0 at a clock edge: state=IDLE, pointers=0, count=0, req=0, wb_ready=1 next cycle, empty=1, chk_hit=0; entry storage need not be cleared.
REQ-021 Reset mid-drain SHALL abandon the outstanding write without waiting for data_ok.

Structure
REQ-022 Shared package SHALL hold WR_TYPE_WORD=3'b010, WR_TYPE_LINE=3'b100, the FSM state encoding, and the LINE_OFS=4 constant.
REQ-023 The entry storage with pointers/count SHALL be one sub-module, wbuf_fifo; FSM, field muxing, and hazard compare remain in victim_wbuf.

Verification
REQ-024 Push line addr=0x1c000040 data=128'h4..1 -> req=1 the next-next cycle, addr=0x1c000040, wr_type=3'b100, wstrb=4'hf; after data_ok, empty=1.
REQ-025 Push 2 entries with addr_ok delayed 5 cycles -> wb_ready=0 after second push, req fields stable for all 5 cycles, FIFO order preserved.
REQ-026 Full FIFO, data_ok and wb_valid same cycle -> no push that cycle (wb_ready=0); push accepted next cycle, count back to DEPTH.
REQ-027 Pending line 0x00001230, chk_addr=0x0000123c -> chk_hit=1; chk_addr=0x00001240 -> chk_hit=0; after data_ok, 0x0000123c -> 0.
REQ-028 Word push addr=0xbfaf8002 wstrb=4'b0100 size=0 -> addr unchanged, wr_type=3'b010, wstrb=4'b0100, wr_data[31:0] correct.
REQ-029 Assert aresetn=0 in WAIT with 2 entries -> next cycle req=0, empty=1, wb_ready=1; a later stray data_ok has no effect.
